// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared encodings and helpers for the iterative
// signed multiply/divide unit.
package multdiv_pkg;

  // Working width of the absolute-value helper; operands are
  // sign-extended into it, so WIDTH must not exceed this.
  localparam int ABS_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  function automatic logic [ABS_W-1:0] abs_tc(
    input logic [ABS_W-1:0] v
  );
    return v[ABS_W-1] ? (~v + ABS_W'(1)) : v;
  endfunction

endpackage

// File: rtl/multdiv_step.sv
// multdiv_step: one unsigned iteration, either shift-add multiply
// or restoring shift-subtract divide over a {hi, lo} register pair.
module multdiv_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    addend = lo[0] ? opnd : '0;
    sum    = {1'b0, hi} + {1'b0, addend};
    shl    = {hi, lo[WIDTH-1]};
    ge     = shl >= {1'b0, opnd};
    // When ge holds the true difference is below opnd, so it fits
    diff   = shl[WIDTH-1:0] - opnd;
    hi_nxt = '0;
    lo_nxt = '0;
    unique case (op)
      OP_MULT: begin
        hi_nxt = sum[WIDTH:1];
        lo_nxt = {sum[0], lo[WIDTH-1:1]};
      end
      OP_DIV: begin
        hi_nxt = ge ? diff : shl[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], ge};
      end
    endcase
  end

endmodule

// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative signed multiply/divide with fixed latency,
// quotient/remainder select, busy flag and start-ignore while busy.
module multdiv_iter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             ctrl_REM,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_e           state;
  op_e              op;
  logic [CNT_W-1:0] cnt;
  logic             rem_sel;
  logic             zero_b;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             start_ok;

  logic               sign_a;
  logic               sign_b;
  logic               neg;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rmd;
  logic [WIDTH-1:0]   fix_res;
  logic               fix_exc;

  assign start_ok = ctrl_MULT ^ ctrl_DIV;
  assign sign_a   = a_q[WIDTH-1];
  assign sign_b   = b_q[WIDTH-1];

  // Magnitudes are formed on the first RUN edge, keeping the
  // negation adders off the operand-capture path.
  assign a_abs = WIDTH'(abs_tc(ABS_W'(signed'(a_q))));
  assign b_abs = WIDTH'(abs_tc(ABS_W'(signed'(b_q))));

  multdiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op     (op),
    .opnd   (opnd),
    .hi     (hi),
    .lo     (lo),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  always_comb begin
    neg  = sign_a ^ sign_b;
    prod = neg ? (~{hi, lo} + (2*WIDTH)'(1)) : {hi, lo};
    quo  = neg ? (~lo + WIDTH'(1)) : lo;
    rmd  = sign_a ? (~hi + WIDTH'(1)) : hi;
    fix_res = '0;
    fix_exc = 1'b0;
    if (op == OP_MULT) begin
      fix_res = prod[WIDTH-1:0];
      fix_exc = ~((&prod[2*WIDTH-1:WIDTH-1]) |
                  ~(|prod[2*WIDTH-1:WIDTH-1]));
    end else if (zero_b) begin
      fix_exc = 1'b1;
    end else if (rem_sel) begin
      fix_res = rmd;
    end else begin
      // Only MIN / -1 gives a positive quotient of 2^(WIDTH-1)
      fix_res = quo;
      fix_exc = ~neg & lo[WIDTH-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      op             <= OP_MULT;
      cnt            <= '0;
      rem_sel        <= 1'b0;
      zero_b         <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      opnd           <= '0;
      hi             <= '0;
      lo             <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state          <= RUN;
            busy           <= 1'b1;
            cnt            <= '0;
            op             <= ctrl_MULT ? OP_MULT : OP_DIV;
            rem_sel        <= ctrl_REM;
            a_q            <= data_operandA;
            b_q            <= data_operandB;
            zero_b         <= ~|data_operandB;
            data_exception <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == '0) begin
            hi   <= '0;
            opnd <= (op == OP_MULT) ? a_abs : b_abs;
            lo   <= (op == OP_MULT) ? b_abs : a_abs;
          end else begin
            hi <= hi_nxt;
            lo <= lo_nxt;
          end
          if (cnt == CNT_W'(WIDTH)) begin
            state <= FIX;
          end
        end
        FIX: begin
          data_result    <= fix_res;
          data_exception <= fix_exc;
          data_resultRDY <= 1'b1;
          state          <= DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// tb_multdiv_iter: scoreboard checks of multdiv_iter at WIDTH=32
// (directed) and WIDTH=8 (directed plus random reference model).
module tb_multdiv_iter;

  typedef struct packed {
    logic        exc;
    logic [31:0] res;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic [31:0] a32, b32, res32;
  logic        mul32, div32, rem32, exc32, rdy32, busy32;
  logic [7:0]  a8, b8, res8;
  logic        mul8, div8, rem8, exc8, rdy8, busy8;

  multdiv_iter #(.WIDTH(32)) u_dut32 (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (a32),
    .data_operandB  (b32),
    .ctrl_MULT      (mul32),
    .ctrl_DIV       (div32),
    .ctrl_REM       (rem32),
    .data_result    (res32),
    .data_exception (exc32),
    .data_resultRDY (rdy32),
    .busy           (busy32)
  );

  multdiv_iter #(.WIDTH(8)) u_dut8 (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (a8),
    .data_operandB  (b8),
    .ctrl_MULT      (mul8),
    .ctrl_DIV       (div8),
    .ctrl_REM       (rem8),
    .data_result    (res8),
    .data_exception (exc8),
    .data_resultRDY (rdy8),
    .busy           (busy8)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rdy_n32 = 0;
  int   rdy_n8 = 0;
  int   t0_32, t0_8, n0;
  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int w, input longint a,
                                 input longint b, input logic mul,
                                 input logic rem);
    longint lo, hi, p, r;
    exp_t   e;
    lo = -(longint'(1) <<< (w - 1));
    hi = -lo - 1;
    e  = '0;
    r  = 0;
    if (mul) begin
      p     = a * b;
      r     = p;
      e.exc = (p < lo) || (p > hi);
    end else if (b == 0) begin
      e.exc = 1'b1;
    end else if (a == lo && b == -1) begin
      r     = rem ? 0 : lo;
      e.exc = ~rem;
    end else begin
      r = rem ? (a % b) : (a / b);
    end
    e.res = 32'(r);
    if (w < 32) e.res = e.res & ((32'd1 << w) - 32'd1);
    return e;
  endfunction

  always @(negedge clock) begin
    if (rdy32) begin
      rdy_n32 <= rdy_n32 + 1;
      chk("sb32_pending", 32'(q32.size() != 0), 32'd1);
      if (q32.size() != 0) begin
        e32 = q32.pop_front();
        chk("res32", res32, e32.res);
        chk("exc32", 32'(exc32), 32'(e32.exc));
      end
    end
    if (rdy8) begin
      rdy_n8 <= rdy_n8 + 1;
      chk("sb8_pending", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        chk("res8", {24'd0, res8}, e8.res);
        chk("exc8", 32'(exc8), 32'(e8.exc));
      end
    end
  end

  task automatic start32(input logic mul, input logic rem,
                         input logic [31:0] a, input logic [31:0] b);
    a32 = a; b32 = b; mul32 = mul; div32 = ~mul; rem32 = rem;
    q32.push_back(model(32, longint'(signed'(a)),
                        longint'(signed'(b)), mul, rem));
    @(posedge clock); #1;
    mul32 = 1'b0; div32 = 1'b0;
    t0_32 = cyc;
    chk("busy32_start", 32'(busy32), 32'd1);
  endtask

  task automatic wait32(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!rdy32 && n < 200);
    chk({tag, "_lat"}, 32'(cyc - t0_32), 32'd34);
    @(posedge clock); #1;
    chk({tag, "_busy_after"}, 32'(busy32), 32'd0);
  endtask

  task automatic start8(input logic mul, input logic rem,
                        input logic [7:0] a, input logic [7:0] b);
    a8 = a; b8 = b; mul8 = mul; div8 = ~mul; rem8 = rem;
    q8.push_back(model(8, longint'(signed'(a)),
                       longint'(signed'(b)), mul, rem));
    @(posedge clock); #1;
    mul8 = 1'b0; div8 = 1'b0;
    t0_8 = cyc;
    chk("busy8_start", 32'(busy8), 32'd1);
  endtask

  // Returns in the RDY cycle so the next start lands on the DONE exit edge
  task automatic wait8(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!rdy8 && n < 100);
    chk({tag, "_lat"}, 32'(cyc - t0_8), 32'd10);
  endtask

  initial begin
    reset_n = 1'b0;
    a32 = '0; b32 = '0; mul32 = 1'b0; div32 = 1'b0; rem32 = 1'b0;
    a8 = '0; b8 = '0; mul8 = 1'b0; div8 = 1'b0; rem8 = 1'b0;
    repeat (2) @(posedge clock); #1;
    chk("rst_res", res32, 32'd0);
    chk("rst_exc", 32'(exc32), 32'd0);
    chk("rst_rdy", 32'(rdy32), 32'd0);
    chk("rst_busy", 32'(busy32), 32'd0);
    chk("rst_busy8", 32'(busy8), 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    start32(1'b1, 1'b0, 32'd7, -32'sd6);         wait32("mul_7x-6");
    start32(1'b1, 1'b0, 32'h10000, 32'h10000);   wait32("mul_ovf");
    start32(1'b1, 1'b0, 32'h80000000, 32'd1);    wait32("mul_min");
    start32(1'b1, 1'b0, 32'd0, 32'h80000000);    wait32("mul_zero");
    start32(1'b0, 1'b0, -32'sd7, 32'd2);         wait32("div_q");
    start32(1'b0, 1'b1, -32'sd7, 32'd2);         wait32("div_r");
    start32(1'b0, 1'b0, 32'h80000000, -32'sd1);  wait32("div_ovf_q");
    start32(1'b0, 1'b1, 32'h80000000, -32'sd1);  wait32("div_ovf_r");
    start32(1'b0, 1'b0, 32'd5, 32'd0);           wait32("div0_q");
    start32(1'b0, 1'b1, 32'd5, 32'd0);           wait32("div0_r");
    start32(1'b0, 1'b1, 32'd100, -32'sd7);       wait32("div_r_pos");

    // Requests while busy must be ignored
    n0 = rdy_n32;
    start32(1'b1, 1'b0, 32'd123, -32'sd45);
    repeat (9) @(posedge clock); #1;
    div32 = 1'b1; a32 = 32'd9; b32 = 32'd3;
    @(posedge clock); #1;
    div32 = 1'b0;
    repeat (9) @(posedge clock); #1;
    mul32 = 1'b1; div32 = 1'b1;
    @(posedge clock); #1;
    mul32 = 1'b0; div32 = 1'b0;
    wait32("ignore");
    repeat (5) @(posedge clock); #1;
    chk("ignore_one_rdy", 32'(rdy_n32 - n0), 32'd1);

    // Reset mid-divide aborts with no RDY
    n0 = rdy_n32;
    start32(1'b0, 1'b0, 32'd100, 32'd7);
    repeat (14) @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    chk("abort_res", res32, 32'd0);
    chk("abort_exc", 32'(exc32), 32'd0);
    chk("abort_busy", 32'(busy32), 32'd0);
    chk("abort_rdy", 32'(rdy32), 32'd0);
    q32.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (60) @(posedge clock); #1;
    chk("abort_no_rdy", 32'(rdy_n32 - n0), 32'd0);
    start32(1'b1, 1'b0, 32'd3, 32'd4);           wait32("mul_3x4");

    // WIDTH=8: directed corners, then random back-to-back traffic
    start8(1'b1, 1'b0, 8'd7, -8'sd6);            wait8("w8_mul");
    start8(1'b1, 1'b0, 8'h10, 8'h10);            wait8("w8_mul_ovf");
    start8(1'b1, 1'b0, 8'h80, 8'd1);             wait8("w8_mul_min");
    start8(1'b0, 1'b0, -8'sd7, 8'd2);            wait8("w8_div_q");
    start8(1'b0, 1'b1, -8'sd7, 8'd2);            wait8("w8_div_r");
    start8(1'b0, 1'b0, 8'h80, 8'hFF);            wait8("w8_div_ovf");
    start8(1'b0, 1'b0, 8'd5, 8'd0);              wait8("w8_div0");
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      int         sel;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 8'd0;
      if (sel == 1) begin ra = 8'h80; rb = 8'hFF; end
      if (sel == 2) ra = 8'd0;
      if (sel == 3) rb = 8'hFF;
      start8(1'($urandom), 1'($urandom), ra, rb);
      wait8("rnd8");
    end

    repeat (20) @(posedge clock); #1;
    chk("sb32_drained", 32'(q32.size()), 32'd0);
    chk("sb8_drained", 32'(q8.size()), 32'd0);
    chk("busy8_idle", 32'(busy8), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
